rpn_stack_alu: RTL
==================

# rpn_stack_alu

Parametrised RPN stack engine for the calculator datapath. It holds the top-of-stack (TOS) in a register and spills deeper entries into a synchronous-read stack RAM. It executes push/pop/arithmetic/stack-manipulation commands through a valid/ready handshake and reports depth, full/empty and sticky error flags to the board-level display and LED logic.

## Interface
Parameters:
- DATA_W, 8, operand/result width
- ADDR_W, 8, stack RAM address width; capacity CAP = 2**ADDR_W entries including TOS

Ports:
- CLOCK_50  in  1  system clock; one clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  3  opcode: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 MUL, 101 DUP, 110 SWAP, 111 CLEAR
- cmd_data  in  DATA_W  PUSH operand; ignored otherwise
- top  out  DATA_W  current TOS (0 when empty)
- depth  out  ADDR_W+1  number of entries, 0..CAP
- empty  out  1  depth==0
- full  out  1  depth==CAP
- done  out  1  one-cycle pulse per completed or rejected command
- err_overflow  out  1  sticky: PUSH/DUP while full
- err_underflow  out  1  sticky: operand missing

## Operation
- Storage: TOS in `top`; entry k below TOS at RAM[depth-1-k]. RAM used indices 0..CAP-2.
- States: S_IDLE (cmd_ready=1), S_READ (cmd_ready=0). Accept = cmd_valid & cmd_ready.
- Single-cycle ops (complete on accept edge, stay S_IDLE):
  - PUSH: if depth>0, write top to RAM[depth-1]; top<=cmd_data; depth++.
  - DUP: write top to RAM[depth-1]; depth++.
  - CLEAR: depth<=0, top<=0, both error flags cleared.
- Two-cycle ops (POP, ADD, SUB, MUL, SWAP): accept edge latches op and presents RAM read address depth-2; go S_READ. The next edge (NOS = RAM read data) completes:
  - POP: top<=NOS; depth--.
  - ADD: top<=NOS+top; SUB: top<=NOS-top; MUL: top<=low DATA_W bits of NOS*top; each does depth--.
  - SWAP: write top to RAM[depth-2]; top<=NOS; depth unchanged.
  - Return to S_IDLE.
- POP with depth==1: completes on accept edge with no read; top<=0, depth<=0.
- Arithmetic wraps modulo 2**DATA_W; there is no carry/sign flag.
- Rejection; stack, top and depth are unchanged; done still pulses:
  - PUSH/DUP at full sets err_overflow.
  - POP/DUP at empty sets err_underflow.
  - ADD/SUB/MUL/SWAP with depth<2 sets err_underflow.
- Error flags are sticky until CLEAR or RESET. Commands continue to execute while flags are set.
- Single RAM port: write and read are never needed in the same cycle.

## Timing
- Reset values: top=0, depth=0, empty=1, full=0, done=0, both error flags 0, cmd_ready=1, state S_IDLE. RAM contents are not reset.
- RESET asserted mid-command (including in S_READ) aborts the command. No done pulse. Reset values apply immediately.
- cmd_valid while cmd_ready=0 is ignored. The source holds the command until accepted.
- Single-cycle and rejected ops: updated outputs and done=1 are visible the cycle after accept. A back-to-back accept is possible every cycle.
- Two-cycle ops: done=1 and new top/depth are visible two cycles after accept. cmd_ready is low for exactly one cycle.
- empty/full are derived combinationally from registered depth.

## Structure
- Package rpn_pkg: opcode constants, state encodings (S_IDLE, S_READ).
- Sub-module stack_ram: single-port, synchronous write, synchronous read (1-cycle latency), parameters DATA_W/ADDR_W.
- The FSM, TOS register, depth counter and ALU live in rpn_stack_alu.

## Test plan
All scenarios use DATA_W=8, ADDR_W=2 (CAP=4).
- Reset -> top=0, depth=0, empty=1, cmd_ready=1, flags 0. PUSH 3, PUSH 4, ADD -> top=7, depth=1, done 2 cycles after ADD accept.
- PUSH 10, PUSH 3, SUB -> top=7. PUSH 200, PUSH 2, MUL -> top=144 (wrap), depth=2.
- PUSH 1,2,3,4, then PUSH 5 -> err_overflow=1, depth=4, full=1, top=4. Then POP ×4 -> tops 3,2,1,0, then empty=1.
- POP at empty -> err_underflow=1, depth=0. PUSH 9, ADD -> err_underflow stays 1, top=9. CLEAR -> flags 0, depth 0.
- PUSH 1, PUSH 2, SWAP -> top=1, depth=2. POP -> top=2. DUP -> top=2, depth=2. ADD -> top=4.
- PUSH 5, PUSH 6, ADD; assert RESET during S_READ -> depth=0, top=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared opcode and FSM state encodings for the RPN stack engine.
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'b000,
    OP_POP   = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_MUL   = 3'b100,
    OP_DUP   = 3'b101,
    OP_SWAP  = 3'b110,
    OP_CLEAR = 3'b111
  } opcode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack RAM: synchronous write, registered read with one-cycle latency.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rpn_stack_alu.sv
// RPN stack engine: TOS register plus spill RAM, valid/ready command interface,
// two-cycle ops fetch the next-on-stack entry from RAM before completing.
module rpn_stack_alu
  import rpn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] top,
  output logic [ADDR_W:0]   depth,
  output logic              empty,
  output logic              full,
  output logic              done,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam logic [ADDR_W:0]   CAP   = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   D_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   D_TWO = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TWO = ADDR_W'(2);

  state_e            state_q, state_d;
  opcode_e           op_q, op_d, op_in;
  logic [DATA_W-1:0] top_q, top_d;
  logic [ADDR_W:0]   depth_q, depth_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic              accept, is_empty, is_full, lt2, needs_read;
  logic [ADDR_W-1:0] addr_m1, addr_m2;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  function automatic logic [DATA_W-1:0] alu_result(input opcode_e op,
                                                   input logic [DATA_W-1:0] nos,
                                                   input logic [DATA_W-1:0] tos);
    case (op)
      OP_ADD:  alu_result = nos + tos;
      OP_SUB:  alu_result = nos - tos;
      OP_MUL:  alu_result = nos * tos;
      default: alu_result = nos;
    endcase
  endfunction

  assign op_in    = opcode_e'(cmd_op);
  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == CAP);
  assign lt2      = (depth_q < D_TWO);
  // RAM addresses wrap modulo CAP, so depth==CAP maps to slot CAP-1.
  assign addr_m1  = depth_q[ADDR_W-1:0] - A_ONE;
  assign addr_m2  = depth_q[ADDR_W-1:0] - A_TWO;

  always_comb begin
    needs_read = 1'b0;
    case (op_in)
      OP_POP, OP_ADD, OP_SUB, OP_MUL, OP_SWAP: needs_read = !lt2;
      default:                                 needs_read = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && needs_read) state_d = S_READ;
      S_READ:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    top_d     = top_q;
    depth_d   = depth_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    op_d      = op_q;
    ram_we    = 1'b0;
    ram_addr  = addr_m1;
    if (state_q == S_IDLE) begin
      if (accept) begin
        op_d   = op_in;
        done_d = 1'b1;
        case (op_in)
          OP_PUSH: begin
            if (is_full) ovf_d = 1'b1;
            else begin
              ram_we  = !is_empty;
              top_d   = cmd_data;
              depth_d = depth_q + D_ONE;
            end
          end
          OP_DUP: begin
            if (is_empty)     unf_d = 1'b1;
            else if (is_full) ovf_d = 1'b1;
            else begin
              ram_we  = 1'b1;
              depth_d = depth_q + D_ONE;
            end
          end
          OP_CLEAR: begin
            top_d   = '0;
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
          end
          OP_POP: begin
            if (is_empty) unf_d = 1'b1;
            else if (depth_q == D_ONE) begin
              top_d   = '0;
              depth_d = '0;
            end else begin
              ram_addr = addr_m2;
              done_d   = 1'b0;
            end
          end
          default: begin
            if (lt2) unf_d = 1'b1;
            else begin
              ram_addr = addr_m2;
              done_d   = 1'b0;
            end
          end
        endcase
      end
    end else begin
      // Completion: RAM read data now holds the next-on-stack entry.
      done_d   = 1'b1;
      ram_addr = addr_m2;
      if (op_q == OP_SWAP) begin
        ram_we = 1'b1;
        top_d  = ram_rdata;
      end else begin
        top_d   = alu_result(op_q, ram_rdata, top_q);
        depth_d = depth_q - D_ONE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      top_q   <= '0;
      depth_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      depth_q <= depth_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge CLOCK_50) op_q <= op_d;

  stack_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk_i   (CLOCK_50),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (top_q),
    .rdata_o (ram_rdata)
  );

  assign top           = top_q;
  assign depth         = depth_q;
  assign empty         = is_empty;
  assign full          = is_full;
  assign done          = done_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule
